pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register. Successor to the fixed-field stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary packed payload of DATA_W bits, e.g. the concatenated wa/wreg/whilo/mreg/dreg/dhilo/dre bundle.
- Adds valid/ready handshaking, synchronous flush and an optional 2-entry skid buffer, so stalls do not need a combinational ready path across the stage.

Parameters:
- DATA_W, 64, payload width in bits (>=1).
- SKID, 1. 1 = 2-entry skid buffer with registered-state in_ready; 0 = single entry, in_ready combinational.
- RESET_VAL, 0, value loaded into payload registers on reset and flush (DATA_W bits).

Ports:
- cpu_clk_50M  in  1  stage clock; all state updates on rising edge.
- cpu_rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous flush; discards all held entries and any same-cycle input.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_data  out  DATA_W  head payload.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready.
- Storage: main register (head, drives out_data) and skid register (used only when SKID=1).
- State encoding is occupancy: EMPTY (0), ONE (1), TWO (2).
- Reset (async, while cpu_rst=1):
  - occupancy=0, out_valid=0, out_data=RESET_VAL, skid=RESET_VAL, in_ready=0.
  - in_ready rises combinationally once cpu_rst deasserts.
- Flush: highest priority after reset.
  - Next edge: occupancy=0, out_valid=0, main=skid=RESET_VAL.
  - A same-cycle push is dropped.
  - A same-cycle pop still counts as handshaken downstream, but no extra state effect.
- in_ready when SKID=1: (occupancy != 2) & ~cpu_rst. Depends only on registered state, with no path from out_ready.
- in_ready when SKID=0: (~out_valid | out_ready) & ~cpu_rst. This is a combinational path from out_ready.
- Latency: a push lands in main or skid at the next edge. Minimum in->out latency is 1 cycle; there is no same-cycle bypass.
- Transitions for SKID=1 (no flush):
  - EMPTY, push: main<=in_data -> ONE.
  - ONE, push & pop: main<=in_data, stay ONE.
  - ONE, push & ~pop: skid<=in_data -> TWO.
  - ONE, ~push & pop: -> EMPTY; main holds its stale value.
  - TWO, pop: main<=skid -> ONE. A push is impossible because in_ready=0.
  - TWO, ~pop: hold.
- Transitions for SKID=0: EMPTY/ONE only, same rules; push & pop in ONE replaces main.
- Ordering: strict FIFO. Entries are never reordered, duplicated or lost except on flush.
- out_valid = (occupancy != 0).
- out_data is stable while out_valid=1 and out_ready=0 (stall): no change to main while held.
- Throughput: 1 payload/cycle sustained when out_ready=1 continuously, in both modes.
- When out_valid=0, out_data is don't-care for consumers, but it must equal RESET_VAL after reset or flush.
- Reset asserted mid-transfer: state is cleared immediately and asynchronously; no partial payload appears after release.

Test Plan:
- Reset: hold cpu_rst=1 with in_valid=1 and in_data=0xAAAA -> out_valid=0, in_ready=0, occupancy=0, out_data=0. After release, in_ready=1 the same cycle.
- Streaming, SKID=1: push 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> out_data shows 0x1..0x4 on cycles 1..4, out_valid=1 each cycle, occupancy stays 1, no drops.
- Stall and skid:
  - Push 0x10 and 0x11 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x10 held.
  - Raise out_ready -> next cycles give 0x10 then 0x11; in_ready returns to 1 after the first pop.
- Flush:
  - With occupancy=2 holding 0x20/0x21, assert flush together with in_valid=1 and in_data=0x22 -> next cycle occupancy=0, out_valid=0, out_data=RESET_VAL.
  - 0x22 never appears.
- SKID=0, DATA_W=8, stall: push 0x5A with out_ready=0 -> in_ready=0 while held. Then out_ready=1 with in_valid=1 and in_data=0x5B in the same cycle -> 0x5B replaces 0x5A next cycle and occupancy stays 1.
- Async reset mid-stall: occupancy=2, assert cpu_rst between clock edges -> out_valid falls without a clock edge. After release, no old payload is emitted.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       SKID      = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              push;
    logic              pop;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;

    always_comb begin
        in_ready       = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        state_nxt      = state;

        // Skid mode derives in_ready purely from registered state.
        if (SKID != 0) begin
            in_ready = (state != TWO) & ~cpu_rst;
        end else begin
            in_ready = (~out_valid | out_ready) & ~cpu_rst;
        end

        push = in_valid & in_ready & ~flush;
        pop  = out_valid & out_ready;

        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push && (SKID != 0)) begin
                        skid_load = 1'b1;
                        state_nxt = TWO;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (flush) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            if (main_load) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (skid_load) begin
                skid_q <= in_data;
            end
        end
    end

endmodule
